// File: rtl/mem_interface_unit.sv
// MAR/MDR memory interface: single-word RAM read/write with ready handshake and timeout.
// Request at edge n drives mem_en from n+1; done/error register one cycle after ready/timeout; requests while busy are ignored.
module mem_interface_unit #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [DATA_W-1:0] BusMuxOut,
   input  logic              MARin,
   input  logic              MDRin,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] BusMuxInMDRout,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t            state, stateNext;
   logic [ADDR_W-1:0] mar, marNext;
   logic [DATA_W-1:0] mdr, mdrNext;
   logic [CNT_W-1:0]  cnt, cntNext;
   logic              enNext, weNext, busyNext, doneNext, errorNext;

   always_ff @(posedge clock) begin
      if (clear) begin
         state  <= IDLE;
         mar    <= '0;
         mdr    <= '0;
         cnt    <= '0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         error  <= 1'b0;
      end else begin
         state  <= stateNext;
         mar    <= marNext;
         mdr    <= mdrNext;
         cnt    <= cntNext;
         mem_en <= enNext;
         mem_we <= weNext;
         busy   <= busyNext;
         done   <= doneNext;
         error  <= errorNext;
      end
   end

   always_comb begin
      stateNext = state;
      marNext   = mar;
      mdrNext   = mdr;
      cntNext   = cnt;
      enNext    = mem_en;
      weNext    = mem_we;
      busyNext  = busy;
      doneNext  = 1'b0;
      errorNext = 1'b0;
      case (state)
         IDLE: begin
            enNext   = 1'b0;
            weNext   = 1'b0;
            busyNext = 1'b0;
            if (MARin) marNext = BusMuxOut[ADDR_W-1:0];
            if (MDRin) mdrNext = BusMuxOut;
            if (rd_req && wr_req) begin
               errorNext = 1'b1;
            end else if (rd_req || wr_req) begin
               stateNext = wr_req ? WR : RD;
               enNext    = 1'b1;
               weNext    = wr_req;
               busyNext  = 1'b1;
               cntNext   = '0;
            end
         end
         RD, WR: begin
            // Ready is checked before the timeout so a last-cycle response still succeeds.
            if (mem_ready) begin
               if (state == RD) mdrNext = mem_rdata;
               stateNext = IDLE;
               enNext    = 1'b0;
               weNext    = 1'b0;
               busyNext  = 1'b0;
               doneNext  = 1'b1;
               cntNext   = '0;
            end else if (cnt == CNT_LAST) begin
               stateNext = IDLE;
               enNext    = 1'b0;
               weNext    = 1'b0;
               busyNext  = 1'b0;
               errorNext = 1'b1;
               cntNext   = '0;
            end else begin
               cntNext = cnt + 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign mem_addr       = mar;
   assign mem_wdata      = mdr;
   assign BusMuxInMDRout = mdr;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed bench for mem_interface_unit: a RAM responder with programmable wait states,
// expected completions queued at each request and popped when done/error appears.
module tb_mem_interface_unit;

   localparam int ADDR_W  = 9;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic              clock = 1'b0;
   logic              clear = 1'b1;
   logic [DATA_W-1:0] BusMuxOut = '0;
   logic              MARin = 1'b0, MDRin = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              mem_en, mem_we, busy, done, error;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, BusMuxInMDRout;

   logic              respReady = 1'b0;
   logic [DATA_W-1:0] respData = '0;
   logic              forceReady = 1'b0;
   int                waitCycles = -1;
   logic [DATA_W-1:0] ram [0:511];

   typedef struct {
      logic              err;
      logic [DATA_W-1:0] mdr;
   } exp_t;
   exp_t              sb[$];
   logic [DATA_W-1:0] mdrModel = '0;
   int                passCnt = 0, totalCnt = 0;

   assign mem_ready = respReady | forceReady;
   assign mem_rdata = forceReady ? 32'h0BAD_CAFE : respData;

   mem_interface_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
      .rd_req(rd_req), .wr_req(wr_req), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .BusMuxInMDRout(BusMuxInMDRout), .busy(busy), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   // RAM responder: raises ready after waitCycles cycles of mem_en (never when negative).
   initial begin
      int rctr;
      rctr = 0;
      for (int i = 0; i < 512; i++) ram[i] = '0;
      ram[9'h105] = 32'hDEAD_BEEF;
      ram[9'h000] = 32'hCAFE_F00D;
      ram[9'h033] = 32'h0BAD_0BAD;
      forever begin
         @(negedge clock);
         if (!mem_en) begin
            rctr = 0;
            respReady = 1'b0;
         end else begin
            respReady = (rctr == waitCycles);
            if (respReady) begin
               respData = ram[mem_addr];
               if (mem_we) ram[mem_addr] = mem_wdata;
            end
            rctr++;
         end
      end
   end

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic runTxn(input string tag, input logic rd, input logic wr, input int waitC,
                         input logic [ADDR_W-1:0] expAddr, input logic expWe, input logic expErr,
                         input logic [DATA_W-1:0] expMdr, input int expEn, input bit junk);
      exp_t e;
      int   enCnt = 0, cyc = 0;
      bit   seen = 0, frozenOk = 1;
      waitCycles = waitC;
      e.err = expErr;
      e.mdr = expMdr;
      sb.push_back(e);
      rd_req = rd;
      wr_req = wr;
      step();
      rd_req = 1'b0;
      wr_req = 1'b0;
      MARin  = 1'b0;
      MDRin  = 1'b0;
      if (junk) begin
         MDRin = 1'b1;
         MARin = 1'b1;
         wr_req = 1'b1;
         BusMuxOut = 32'hFFFF_FFFF;
      end
      for (int i = 0; i < TIMEOUT + 4 && !seen; i++) begin
         @(negedge clock);
         cyc++;
         if (mem_en) begin
            enCnt++;
            if (mem_addr !== expAddr || mem_we !== expWe || BusMuxInMDRout !== mdrModel
                || mem_wdata !== mdrModel || busy !== 1'b1)
               frozenOk = 0;
         end
         if (done || error) seen = 1;
      end
      if (junk) begin
         MDRin = 1'b0;
         MARin = 1'b0;
         wr_req = 1'b0;
      end
      chk({tag, "/completes"}, 32'(seen), 32'd1);
      e = sb.pop_front();
      if (seen) begin
         chk({tag, "/error"}, 32'(error), 32'(e.err));
         chk({tag, "/done"}, 32'(done), 32'(!e.err));
         chk({tag, "/mdr"}, BusMuxInMDRout, e.mdr);
         chk({tag, "/busy_low"}, 32'(busy), 32'd0);
         chk({tag, "/en_low"}, 32'(mem_en), 32'd0);
         chk({tag, "/en_cycles"}, 32'(enCnt), 32'(expEn));
         chk({tag, "/latency"}, 32'(cyc), 32'(expEn + 1));
         chk({tag, "/held_during_txn"}, 32'(frozenOk), 32'd1);
      end
      mdrModel = e.mdr;
   endtask

   initial begin
      // Reset state
      step();
      step();
      clear = 1'b0;
      @(negedge clock);
      chk("rst/mem_en", 32'(mem_en), 32'd0);
      chk("rst/mem_we", 32'(mem_we), 32'd0);
      chk("rst/busy", 32'(busy), 32'd0);
      chk("rst/done", 32'(done), 32'd0);
      chk("rst/error", 32'(error), 32'd0);
      chk("rst/mem_addr", 32'(mem_addr), 32'd0);
      chk("rst/mdr", BusMuxInMDRout, 32'd0);

      // Bus load of MAR, then read with two wait cycles
      MARin = 1'b1;
      BusMuxOut = 32'h0000_0105;
      step();
      MARin = 1'b0;
      runTxn("read", 1, 0, 2, 9'h105, 0, 0, 32'hDEAD_BEEF, 3, 0);
      @(negedge clock);
      chk("read/done_one_pulse", 32'(done), 32'd0);

      // Write: MDR from bus, MAR loaded in the request cycle, zero wait
      MDRin = 1'b1;
      BusMuxOut = 32'h1234_5678;
      step();
      MDRin = 1'b0;
      mdrModel = 32'h1234_5678;
      MARin = 1'b1;
      BusMuxOut = 32'h0000_000A;
      runTxn("write", 0, 1, 0, 9'h00A, 1, 0, 32'h1234_5678, 1, 0);
      chk("write/ram", ram[9'h00A], 32'h1234_5678);
      @(negedge clock);
      chk("write/done_one_pulse", 32'(done), 32'd0);

      // Timeout with no response; MDR keeps its value
      runTxn("timeout", 1, 0, -1, 9'h00A, 0, 1, 32'h1234_5678, TIMEOUT, 0);
      @(negedge clock);
      chk("timeout/error_one_pulse", 32'(error), 32'd0);

      // Ready on the last allowed cycle succeeds
      MARin = 1'b1;
      BusMuxOut = 32'h0000_0105;
      step();
      MARin = 1'b0;
      runTxn("lastcycle", 1, 0, TIMEOUT - 1, 9'h105, 0, 0, 32'hDEAD_BEEF, TIMEOUT, 0);
      step();

      // Simultaneous read and write requests
      runTxn("both_req", 1, 1, 0, 9'h105, 0, 1, 32'hDEAD_BEEF, 0, 0);
      @(negedge clock);
      chk("both_req/error_one_pulse", 32'(error), 32'd0);
      chk("both_req/en_still_low", 32'(mem_en), 32'd0);

      // Bus loads and requests during a read are ignored
      MARin = 1'b1;
      BusMuxOut = 32'h0000_000A;
      step();
      MARin = 1'b0;
      runTxn("rd_junk", 1, 0, 2, 9'h00A, 0, 0, 32'h1234_5678, 3, 1);
      @(negedge clock);
      chk("rd_junk/mar_kept", 32'(mem_addr), 32'h00A);
      chk("rd_junk/no_new_txn", 32'(busy), 32'd0);

      // Clear during the first wait cycle of a read
      waitCycles = -1;
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      @(negedge clock);
      chk("clr/busy_before", 32'(busy), 32'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      @(negedge clock);
      chk("clr/mem_en", 32'(mem_en), 32'd0);
      chk("clr/busy", 32'(busy), 32'd0);
      chk("clr/done_err", 32'({done, error}), 32'd0);
      chk("clr/mar", 32'(mem_addr), 32'd0);
      chk("clr/mdr", BusMuxInMDRout, 32'd0);
      forceReady = 1'b1;
      step();
      forceReady = 1'b0;
      @(negedge clock);
      chk("clr/late_ready_ignored", 32'({done, error, busy}), 32'd0);
      chk("clr/mdr_after_ready", BusMuxInMDRout, 32'd0);
      mdrModel = '0;
      runTxn("post_clr", 1, 0, 1, 9'h000, 0, 0, 32'hCAFE_F00D, 2, 0);
      step();

      // Back-to-back write then read of the same address
      MDRin = 1'b1;
      BusMuxOut = 32'hA5A5_5A5A;
      step();
      MDRin = 1'b0;
      mdrModel = 32'hA5A5_5A5A;
      MARin = 1'b1;
      BusMuxOut = 32'h0000_0033;
      runTxn("b2b_wr", 0, 1, 0, 9'h033, 1, 0, 32'hA5A5_5A5A, 1, 0);
      runTxn("b2b_rd", 1, 0, 0, 9'h033, 0, 0, 32'hA5A5_5A5A, 1, 0);
      chk("b2b/ram", ram[9'h033], 32'hA5A5_5A5A);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
